// File: rtl/partition_error_meter_if.sv
// partition_error_meter_if
//  Bundles the sweep control, the partition drive/sample words and the
//  metric readout of one partition error meter.
//  Ports (signals):
//    start, abort             sweep control into the meter
//    pi                       vector driven onto both partitions
//    po_exact, po_approx      exact / approximate partition outputs
//    busy, done               sweep status
//    err_count, hd_sum,
//    abs_err_sum, max_abs_err accumulated error metrics
//  Modports: master = stimulus/partition side, slave = the meter itself.
interface partition_error_meter_if #(
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4
);
  localparam int HDW = NUM_IN + $clog2(NUM_OUT + 1);

  logic                       start;
  logic                       abort;
  logic [NUM_IN-1:0]          pi;
  logic [NUM_OUT-1:0]         po_exact;
  logic [NUM_OUT-1:0]         po_approx;
  logic                       busy;
  logic                       done;
  logic [NUM_IN:0]            err_count;
  logic [HDW-1:0]             hd_sum;
  logic [NUM_IN+NUM_OUT-1:0]  abs_err_sum;
  logic [NUM_OUT-1:0]         max_abs_err;

  modport master (
    output start, abort, po_exact, po_approx,
    input  pi, busy, done, err_count, hd_sum, abs_err_sum, max_abs_err
  );

  modport slave (
    input  start, abort, po_exact, po_approx,
    output pi, busy, done, err_count, hd_sum, abs_err_sum, max_abs_err
  );
endinterface

// File: rtl/partition_error_meter.sv
// partition_error_meter
//  Exhaustive-sweep error meter for one approximated partition. Walks pi
//  through every input vector, waits SETTLE cycles per vector, then samples
//  the exact and approximate outputs and accumulates error count, Hamming
//  distance sum, absolute error sum and maximum absolute error.
//  Ports:
//    clk   in  rising-edge clock
//    rst   in  synchronous active-high reset
//    bus   slave modport of partition_error_meter_if (control, pi, po_*,
//          busy/done and the four metrics)
module partition_error_meter #(
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4,
  parameter int SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  partition_error_meter_if.slave   bus
);

  localparam int HW   = $clog2(NUM_OUT + 1);
  localparam int ERRW = NUM_IN + 1;
  localparam int HDW  = NUM_IN + HW;
  localparam int ABSW = NUM_IN + NUM_OUT;
  localparam int CW   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // With no settle time the sweep skips DRIVE and samples every cycle.
  localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : DRIVE;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_IN-1:0]   r_pi;
  logic [CW-1:0]       r_cnt;
  logic [ERRW-1:0]     r_err_count;
  logic [HDW-1:0]      r_hd_sum;
  logic [ABSW-1:0]     r_abs_err_sum;
  logic [NUM_OUT-1:0]  r_max_abs_err;

  logic                w_idle_like;
  logic                w_busy_like;
  logic                w_take_start;
  logic                w_take_abort;
  logic                w_last;
  logic                w_settled;
  logic [NUM_OUT-1:0]  w_xor;
  logic [NUM_OUT-1:0]  w_diff;
  logic [HW-1:0]       w_hd;
  logic                w_busy;
  logic                w_done;

  assign w_idle_like  = (r_state == IDLE) || (r_state == DONE);
  assign w_busy_like  = (r_state == DRIVE) || (r_state == SAMPLE);
  assign w_take_start = w_idle_like && bus.start;
  assign w_take_abort = w_busy_like && bus.abort;
  assign w_last       = &r_pi;
  // The counter is decremented on the same edge that leaves DRIVE, so the
  // transition fires while it still reads 1.
  assign w_settled    = (r_cnt <= CW'(1));

  // Per-vector error terms from the two partition outputs.
  assign w_xor  = bus.po_exact ^ bus.po_approx;
  assign w_diff = (bus.po_exact >= bus.po_approx) ? (bus.po_exact - bus.po_approx)
                                                  : (bus.po_approx - bus.po_exact);

  // Popcount of the differing output bits.
  always_comb begin
    w_hd = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_hd = w_hd + HW'(w_xor[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort beats everything while busy, start is only
  // looked at when idle or done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_take_start) w_next = FIRST;
      DRIVE: begin
        if (w_take_abort)   w_next = IDLE;
        else if (w_settled) w_next = SAMPLE;
      end
      SAMPLE: begin
        if (w_take_abort) w_next = IDLE;
        else if (w_last)  w_next = DONE;
        else              w_next = FIRST;
      end
      DONE:    if (w_take_start) w_next = FIRST;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      DRIVE, SAMPLE: w_busy = 1'b1;
      DONE:          w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Sweep datapath: vector pointer, settle counter and metric accumulators.
  // An aborted sample is simply not accumulated; pi and metrics hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pi          <= '0;
      r_cnt         <= '0;
      r_err_count   <= '0;
      r_hd_sum      <= '0;
      r_abs_err_sum <= '0;
      r_max_abs_err <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_take_start) begin
            r_pi          <= '0;
            r_cnt         <= SETTLE_LD;
            r_err_count   <= '0;
            r_hd_sum      <= '0;
            r_abs_err_sum <= '0;
            r_max_abs_err <= '0;
          end
        end
        DRIVE: begin
          if (!w_take_abort) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        SAMPLE: begin
          if (!w_take_abort) begin
            r_err_count   <= r_err_count + ERRW'(w_diff != '0);
            r_hd_sum      <= r_hd_sum + HDW'(w_hd);
            r_abs_err_sum <= r_abs_err_sum + ABSW'(w_diff);
            if (w_diff > r_max_abs_err) begin
              r_max_abs_err <= w_diff;
            end
            if (!w_last) begin
              r_pi  <= r_pi + NUM_IN'(1);
              r_cnt <= SETTLE_LD;
            end
          end
        end
        default: begin
          r_pi <= r_pi;
        end
      endcase
    end
  end

  assign bus.pi          = r_pi;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.err_count   = r_err_count;
  assign bus.hd_sum      = r_hd_sum;
  assign bus.abs_err_sum = r_abs_err_sum;
  assign bus.max_abs_err = r_max_abs_err;

endmodule

// File: tb/tb_partition_error_meter.sv
// tb_partition_error_meter
//  Drives two meters (SETTLE=1 and SETTLE=0) against a configurable pair of
//  partition models and compares metrics, sweep length, abort and reset
//  behaviour with a vector-by-vector reference computed in the bench.
module tb_partition_error_meter;

  localparam int NVEC = 64;

  logic clk = 1'b0;
  logic rst;

  partition_error_meter_if #(.NUM_IN(6), .NUM_OUT(4)) bus1 ();
  partition_error_meter_if #(.NUM_IN(6), .NUM_OUT(4)) bus0 ();

  partition_error_meter #(.NUM_IN(6), .NUM_OUT(4), .SETTLE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  partition_error_meter #(.NUM_IN(6), .NUM_OUT(4), .SETTLE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  // Partition behaviour: 0 identical, 1 bit0 forced low, 2 MSB flipped,
  // 3 independent random tables for exact and approx.
  int         mode;
  logic [3:0] lutE [NVEC];
  logic [3:0] lutA [NVEC];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int expErr;
    int expHd;
    int expAbs;
    int expMax;
  } vec_t;

  vec_t vecs [3];

  // Exact partition outputs for both meters.
  always_comb begin
    bus1.po_exact = (mode == 3) ? lutE[bus1.pi] : bus1.pi[3:0];
    bus0.po_exact = (mode == 3) ? lutE[bus0.pi] : bus0.pi[3:0];
  end

  // Approximate partition outputs for both meters.
  always_comb begin
    bus1.po_approx = bus1.po_exact;
    bus0.po_approx = bus0.po_exact;
    case (mode)
      1: begin
        bus1.po_approx = bus1.po_exact & 4'hE;
        bus0.po_approx = bus0.po_exact & 4'hE;
      end
      2: begin
        bus1.po_approx = bus1.po_exact ^ 4'h8;
        bus0.po_approx = bus0.po_exact ^ 4'h8;
      end
      3: begin
        bus1.po_approx = lutA[bus1.pi];
        bus0.po_approx = lutA[bus0.pi];
      end
      default: begin
        bus1.po_approx = bus1.po_exact;
        bus0.po_approx = bus0.po_exact;
      end
    endcase
  end

  function automatic int refExact(int v);
    if (mode == 3) return int'(lutE[v]);
    return v % 16;
  endfunction

  function automatic int refApprox(int v);
    int e;
    e = refExact(v);
    case (mode)
      1:       return e - (e % 2);
      2:       return (e >= 8) ? e - 8 : e + 8;
      3:       return int'(lutA[v]);
      default: return e;
    endcase
  endfunction

  // Reference metrics over vectors 0..upto-1.
  task automatic refMetrics(input int upto, output int ec, output int hd,
                            output int ab, output int mx);
    int e, a, d;
    logic [3:0] x;
    ec = 0; hd = 0; ab = 0; mx = 0;
    for (int v = 0; v < upto; v++) begin
      e = refExact(v);
      a = refApprox(v);
      d = (e > a) ? e - a : a - e;
      x = 4'(e) ^ 4'(a);
      if (d != 0) ec++;
      hd += $countones(x);
      ab += d;
      if (d > mx) mx = d;
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkMetrics(input string tag, input int ec, input int hd,
                              input int ab, input int mx, input int eEc,
                              input int eHd, input int eAb, input int eMx);
    checkOutput({tag, ".err_count"},   ec, eEc);
    checkOutput({tag, ".hd_sum"},      hd, eHd);
    checkOutput({tag, ".abs_err_sum"}, ab, eAb);
    checkOutput({tag, ".max_abs_err"}, mx, eMx);
  endtask

  // Pulse start on the selected meters for one clock; returns on the
  // negedge right after the edge that took it.
  task automatic applyStimulus(input bit s1, input bit s0);
    @(negedge clk);
    bus1.start = s1;
    bus0.start = s0;
    @(negedge clk);
    bus1.start = 1'b0;
    bus0.start = 1'b0;
  endtask

  // Counts edges since start until each meter shows done (-1 on timeout);
  // optionally pulses start on both meters at edge count pulseAt.
  task automatic waitDone(input int pulseAt, output int c1, output int c0);
    c1 = -1;
    c0 = -1;
    for (int n = 0; n <= 300; n++) begin
      if (c1 < 0 && bus1.done) c1 = n;
      if (c0 < 0 && bus0.done) c0 = n;
      if (c1 >= 0 && c0 >= 0) break;
      if (n == pulseAt) begin
        bus1.start = 1'b1;
        bus0.start = 1'b1;
      end
      if (n == pulseAt + 1) begin
        bus1.start = 1'b0;
        bus0.start = 1'b0;
      end
      @(negedge clk);
    end
    bus1.start = 1'b0;
    bus0.start = 1'b0;
  endtask

  task automatic randomLuts();
    for (int v = 0; v < NVEC; v++) begin
      lutE[v] = 4'($urandom_range(0, 15));
      lutA[v] = (($urandom_range(0, 3)) == 0) ? lutE[v] : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    int c1, c0, ec, hd, ab, mx, found;

    vecs[0] = '{mode: 0, expErr: 0,  expHd: 0,  expAbs: 0,   expMax: 0};
    vecs[1] = '{mode: 1, expErr: 32, expHd: 32, expAbs: 32,  expMax: 1};
    vecs[2] = '{mode: 2, expErr: 64, expHd: 64, expAbs: 512, expMax: 8};

    mode = 0;
    for (int v = 0; v < NVEC; v++) begin
      lutE[v] = '0;
      lutA[v] = '0;
    end
    rst = 1'b1;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    checkOutput("rst.busy1", int'(bus1.busy), 0);
    checkOutput("rst.done1", int'(bus1.done), 0);
    checkOutput("rst.pi1",   int'(bus1.pi),   0);
    checkMetrics("rst1", int'(bus1.err_count), int'(bus1.hd_sum),
                 int'(bus1.abs_err_sum), int'(bus1.max_abs_err), 0, 0, 0, 0);
    checkOutput("rst.busy0", int'(bus0.busy), 0);
    checkOutput("rst.done0", int'(bus0.done), 0);

    // abort while idle is ignored
    @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    checkOutput("idleAbort.busy", int'(bus1.busy), 0);

    // Table-driven full sweeps with known metrics.
    for (int t = 0; t < 3; t++) begin
      mode = vecs[t].mode;
      applyStimulus(1'b1, 1'b1);
      waitDone(-10, c1, c0);
      checkOutput($sformatf("tab%0d.cycles1", t), c1, 128);
      checkOutput($sformatf("tab%0d.cycles0", t), c0, 64);
      checkOutput($sformatf("tab%0d.pi1", t), int'(bus1.pi), 63);
      checkMetrics($sformatf("tab%0d.s1", t), int'(bus1.err_count), int'(bus1.hd_sum),
                   int'(bus1.abs_err_sum), int'(bus1.max_abs_err),
                   vecs[t].expErr, vecs[t].expHd, vecs[t].expAbs, vecs[t].expMax);
      checkMetrics($sformatf("tab%0d.s0", t), int'(bus0.err_count), int'(bus0.hd_sum),
                   int'(bus0.abs_err_sum), int'(bus0.max_abs_err),
                   vecs[t].expErr, vecs[t].expHd, vecs[t].expAbs, vecs[t].expMax);
    end

    // Randomised partitions against the reference model.
    mode = 3;
    for (int r = 0; r < 4; r++) begin
      randomLuts();
      refMetrics(NVEC, ec, hd, ab, mx);
      applyStimulus(1'b1, 1'b1);
      waitDone(-10, c1, c0);
      checkOutput($sformatf("rnd%0d.cycles1", r), c1, 128);
      checkOutput($sformatf("rnd%0d.cycles0", r), c0, 64);
      checkMetrics($sformatf("rnd%0d.s1", r), int'(bus1.err_count), int'(bus1.hd_sum),
                   int'(bus1.abs_err_sum), int'(bus1.max_abs_err), ec, hd, ab, mx);
      checkMetrics($sformatf("rnd%0d.s0", r), int'(bus0.err_count), int'(bus0.hd_sum),
                   int'(bus0.abs_err_sum), int'(bus0.max_abs_err), ec, hd, ab, mx);
    end

    // Abort at pi=10 in DRIVE: partial metrics over vectors 0..9 hold.
    randomLuts();
    applyStimulus(1'b1, 1'b0);
    found = 0;
    for (int n = 0; n < 300; n++) begin
      if (bus1.pi == 6'd10 && bus1.busy) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort.reach", found, 1);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    refMetrics(10, ec, hd, ab, mx);
    checkOutput("abort.busy", int'(bus1.busy), 0);
    checkOutput("abort.done", int'(bus1.done), 0);
    checkOutput("abort.pi",   int'(bus1.pi),   10);
    checkMetrics("abort", int'(bus1.err_count), int'(bus1.hd_sum),
                 int'(bus1.abs_err_sum), int'(bus1.max_abs_err), ec, hd, ab, mx);
    repeat (3) @(negedge clk);
    checkOutput("abort.staysIdle", int'(bus1.busy), 0);

    // start and abort together while idle: start wins, metrics cleared.
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    checkOutput("startWins.busy", int'(bus1.busy), 1);
    checkOutput("startWins.clear", int'(bus1.err_count), 0);
    checkOutput("startWins.pi", int'(bus1.pi), 0);
    waitDone(-10, c1, c0);
    refMetrics(NVEC, ec, hd, ab, mx);
    checkOutput("restart.cycles", c1, 128);
    checkMetrics("restart", int'(bus1.err_count), int'(bus1.hd_sum),
                 int'(bus1.abs_err_sum), int'(bus1.max_abs_err), ec, hd, ab, mx);

    // start pulsed mid-sweep is ignored.
    mode = 2;
    applyStimulus(1'b1, 1'b1);
    waitDone(40, c1, c0);
    checkOutput("midStart.cycles1", c1, 128);
    checkOutput("midStart.cycles0", c0, 64);
    checkMetrics("midStart", int'(bus1.err_count), int'(bus1.hd_sum),
                 int'(bus1.abs_err_sum), int'(bus1.max_abs_err), 64, 64, 512, 8);

    // Reset mid-sweep at pi=20.
    applyStimulus(1'b1, 1'b0);
    found = 0;
    for (int n = 0; n < 300; n++) begin
      if (bus1.pi == 6'd20) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rstMid.reach", found, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMid.busy", int'(bus1.busy), 0);
    checkOutput("rstMid.done", int'(bus1.done), 0);
    checkOutput("rstMid.pi",   int'(bus1.pi),   0);
    checkMetrics("rstMid", int'(bus1.err_count), int'(bus1.hd_sum),
                 int'(bus1.abs_err_sum), int'(bus1.max_abs_err), 0, 0, 0, 0);
    checkOutput("rstMid.done0", int'(bus0.done), 0);
    checkOutput("rstMid.err0",  int'(bus0.err_count), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
